// File: rtl/melbank_filter_reader.sv
// Mel filterbank consumer: walks one filter's coefficient ROM in step with the
// incoming FFT power bins, hides the ROM's one-cycle read latency and
// accumulates a single saturating filter energy per frame.
module melbank_filter_reader #(
   parameter int ADDR_WIDTH = 9,
   parameter int COEF_WIDTH = 8,
   parameter int PWR_WIDTH  = 32,
   parameter int ACC_WIDTH  = 48,
   parameter int NUM_BINS   = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [PWR_WIDTH-1:0]  s_data,
   input  logic                  s_last,
   output logic [ADDR_WIDTH-1:0] addr,
   input  logic [COEF_WIDTH-1:0] rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ACC_WIDTH-1:0]  m_data,
   output logic                  m_overflow,
   output logic                  err_len
);

   localparam int PROD_W = PWR_WIDTH + COEF_WIDTH;

   typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] bin_cnt;
   logic [PWR_WIDTH-1:0]  p1_pwr;
   logic                  p1_valid;
   logic [ACC_WIDTH-1:0]  acc;
   logic                  ovf;
   logic                  err;

   logic                  xfer;
   logic                  cnt_end;
   logic                  frame_end;
   logic                  handoff;
   logic [PROD_W-1:0]     prod;
   logic [ACC_WIDTH:0]    sum;
   logic                  sat;

   assign xfer      = s_valid & s_ready;
   assign cnt_end   = (bin_cnt == ADDR_WIDTH'(NUM_BINS - 1));
   // The bin counter also ends the frame so a missing s_last can never wrap it.
   assign frame_end = xfer & (s_last | cnt_end);
   assign handoff   = (state == HOLD) & m_ready;

   // Weight arrives one cycle after the address, aligned with the staged power.
   assign prod = PROD_W'(p1_pwr) * PROD_W'(rd_data);
   assign sum  = {1'b0, acc} + (ACC_WIDTH + 1)'(prod);
   assign sat  = sum[ACC_WIDTH];

   assign addr       = bin_cnt;
   assign m_data     = acc;
   assign m_overflow = ovf;
   assign err_len    = err;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next state: DRAIN is the single cycle the last product needs to land in acc
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (frame_end) state_nxt = DRAIN;
         DRAIN:   state_nxt = HOLD;
         HOLD:    if (m_ready) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      s_ready = (state == RUN);
      m_valid = (state == HOLD);
   end

   // Datapath: bin counter, power stage, saturating accumulator and frame flags
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_cnt  <= '0;
         p1_pwr   <= '0;
         p1_valid <= 1'b0;
         acc      <= '0;
         ovf      <= 1'b0;
         err      <= 1'b0;
      end else begin
         p1_valid <= xfer;
         if (xfer) begin
            p1_pwr  <= s_data;
            bin_cnt <= (s_last | cnt_end) ? '0 : bin_cnt + 1'b1;
         end
         if (handoff) begin
            acc <= '0;
            ovf <= 1'b0;
            err <= 1'b0;
         end else begin
            if (p1_valid) begin
               // Once saturated, any further carry keeps acc pinned at all ones.
               acc <= sat ? '1 : sum[ACC_WIDTH-1:0];
               if (sat) ovf <= 1'b1;
            end
            if (frame_end && !cnt_end) err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_melbank_filter_reader.sv
// Directed bench for melbank_filter_reader: a 48-bit and a 40-bit accumulator
// instance run in lockstep, each fed by its own registered ROM model.
module tb_melbank_filter_reader;

   logic        clk = 1'b0;
   logic        tb_rst;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_last;
   logic        m_ready;

   logic        s_ready, s_ready40;
   logic [8:0]  addr, addr40;
   logic [7:0]  rd_data, rd_data40;
   logic        m_valid, m_valid40;
   logic [47:0] m_data;
   logic [39:0] m_data40;
   logic        m_overflow, m_overflow40;
   logic        err_len, err_len40;

   int          rom_mode;
   int          passes = 0;
   int          fails  = 0;

   always #5 clk = ~clk;

   melbank_filter_reader dut (
      .clk(clk), .rst(tb_rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .addr(addr), .rd_data(rd_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_overflow(m_overflow), .err_len(err_len)
   );

   melbank_filter_reader #(.ACC_WIDTH(40)) dut40 (
      .clk(clk), .rst(tb_rst), .s_valid(s_valid), .s_ready(s_ready40), .s_data(s_data),
      .s_last(s_last), .addr(addr40), .rd_data(rd_data40), .m_valid(m_valid40),
      .m_ready(m_ready), .m_data(m_data40), .m_overflow(m_overflow40), .err_len(err_len40)
   );

   // ROM weight: mode 1 is address-indexed, the others are flat 0xFF
   function automatic logic [7:0] weight(input int mode, input logic [8:0] a);
      return (mode == 1) ? a[7:0] : 8'hFF;
   endfunction

   function automatic logic [31:0] bin_data(input int mode, input int i);
      case (mode)
         1:       return 32'(i);
         2:       return 32'hFFFF_FFFF;
         default: return 32'd1;
      endcase
   endfunction

   // One-cycle-latency ROMs
   always @(posedge clk) begin
      rd_data   <= weight(rom_mode, addr);
      rd_data40 <= weight(rom_mode, addr40);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream n bins; when the frame is expected to close, check m_valid is low
   // just after the last transfer and high one edge later.
   task automatic run_frame(input int n, input int mode, input bit use_last,
                            input bit bubbles, input bit expect_end);
      rom_mode = mode;
      for (int i = 0; i < n; i++) begin
         if (bubbles && (i % 3 == 2)) begin
            s_valid = 1'b0;
            tick();
         end
         s_valid = 1'b1;
         s_data  = bin_data(mode, i);
         s_last  = use_last && (i == n - 1);
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      if (expect_end) begin
         chk("lat_drain_mvalid", 64'(m_valid), 64'd0);
         chk("lat_drain_sready", 64'(s_ready), 64'd0);
         tick();
         chk("lat_hold_mvalid", 64'(m_valid), 64'd1);
      end
   endtask

   // Accept the result and check the block is back to an empty RUN state
   task automatic release_result();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("rel_mvalid", 64'(m_valid), 64'd0);
      chk("rel_sready", 64'(s_ready), 64'd1);
      chk("rel_acc_clear", 64'(m_data), 64'd0);
      chk("rel_err_clear", 64'(err_len), 64'd0);
      chk("rel_ovf_clear", 64'(m_overflow), 64'd0);
      chk("rel_addr", 64'(addr), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tb_rst   = 1'b1;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      m_ready  = 1'b0;
      rom_mode = 0;
      tick();
      tick();
      tb_rst = 1'b0;
      tick();

      // Reset state
      chk("rst_sready", 64'(s_ready), 64'd1);
      chk("rst_mvalid", 64'(m_valid), 64'd0);
      chk("rst_mdata", 64'(m_data), 64'd0);
      chk("rst_ovf", 64'(m_overflow), 64'd0);
      chk("rst_err", 64'(err_len), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);

      // 1: flat weights, unit power, no s_last (count end closes the frame),
      //    m_ready held high throughout so it must be ignored until HOLD
      m_ready = 1'b1;
      run_frame(512, 0, 1'b0, 1'b0, 1'b1);
      chk("t1_mdata", 64'(m_data), 64'd130560);
      chk("t1_ovf", 64'(m_overflow), 64'd0);
      chk("t1_err", 64'(err_len), 64'd0);
      release_result();

      // 2: indexed weights, s_data=i: sum i*(i&0xFF) = 5559680 + 13915520
      run_frame(512, 1, 1'b1, 1'b0, 1'b1);
      chk("t2_mdata", 64'(m_data), 64'd19475200);
      chk("t2_err", 64'(err_len), 64'd0);
      release_result();

      // 2b: same frame with a bubble every third cycle
      run_frame(512, 1, 1'b1, 1'b1, 1'b1);
      chk("t2b_mdata", 64'(m_data), 64'd19475200);

      // 3: hold off downstream for 10 cycles while junk is offered upstream
      s_valid = 1'b1;
      s_data  = 32'hDEAD_BEEF;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t3_sready", 64'(s_ready), 64'd0);
         chk("t3_mvalid", 64'(m_valid), 64'd1);
         chk("t3_mdata", 64'(m_data), 64'd19475200);
         chk("t3_addr", 64'(addr), 64'd0);
      end
      s_valid = 1'b0;
      s_data  = '0;
      release_result();

      // 4: short frame ending on bin 99: sum i^2 for 0..99
      run_frame(100, 1, 1'b1, 1'b0, 1'b1);
      chk("t4_mdata", 64'(m_data), 64'd328350);
      chk("t4_err", 64'(err_len), 64'd1);
      release_result();
      run_frame(512, 0, 1'b1, 1'b0, 1'b1);
      chk("t4_full_mdata", 64'(m_data), 64'd130560);
      chk("t4_full_err", 64'(err_len), 64'd0);
      release_result();

      // 5: max power, max weight: both widths saturate
      run_frame(512, 2, 1'b1, 1'b0, 1'b1);
      chk("t5_mdata40", 64'(m_data40), 64'hFF_FFFF_FFFF);
      chk("t5_ovf40", 64'(m_overflow40), 64'd1);
      chk("t5_mvalid40", 64'(m_valid40), 64'd1);
      chk("t5_mdata48", 64'(m_data), 64'hFFFF_FFFF_FFFF);
      chk("t5_ovf48", 64'(m_overflow), 64'd1);
      release_result();
      run_frame(512, 0, 1'b1, 1'b0, 1'b1);
      chk("t5_next_mdata40", 64'(m_data40), 64'd130560);
      chk("t5_next_ovf40", 64'(m_overflow40), 64'd0);
      release_result();

      // 6: reset after 200 bins discards the partial frame
      run_frame(200, 0, 1'b0, 1'b0, 1'b0);
      chk("t6_pre_addr", 64'(addr), 64'd200);
      tb_rst = 1'b1;
      tick();
      tb_rst = 1'b0;
      chk("t6_addr", 64'(addr), 64'd0);
      chk("t6_mdata", 64'(m_data), 64'd0);
      chk("t6_sready", 64'(s_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         chk("t6_no_mvalid", 64'(m_valid), 64'd0);
         tick();
      end
      chk("t6_acc_idle", 64'(m_data), 64'd0);
      run_frame(512, 0, 1'b1, 1'b0, 1'b1);
      chk("t6_full_mdata", 64'(m_data), 64'd130560);
      chk("t6_full_err", 64'(err_len), 64'd0);
      release_result();

      $display("%0d/%0d checks passed", passes, passes + fails);
      $finish;
   end

endmodule
